// File: rtl/alu_unit.sv
// alu_unit: multi-cycle RV32I integer / compare execution lane.
//
// Accepts one operation while busy_in is high in IDLE and returns a single-cycle
// done pulse carrying the result value and ROB tag. Shifts run iteratively,
// at most SHIFT_STEP bit positions per cycle. Every other operation takes a
// fixed two cycles from accept to done.
//
// Ports
//   clk_in        system clock
//   rst_in        synchronous active-high reset
//   rdy_in        global enable; when low, all state and outputs hold
//   clear_signal  misprediction flush; aborts any in-flight operation
//   busy_in       task-valid level from the reservation station
//   opcode_in     operation select (see OP_* below)
//   lhs_in        operand 1
//   rhs_in        operand 2
//   rd_tag_in     destination ROB tag
//   done_out      result-valid pulse
//   value_out     result value
//   tag_out       ROB tag of the result
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for busy_in; operands are latched on the accept edge
// EXEC   | single-cycle compute of a non-shift operation
// SHIFT  | iterative shift; cnt holds the remaining distance
// DONE   | done_out is high; busy_in is ignored until we return to IDLE
module alu_unit #(
  parameter int ROB_WIDTH  = 4,
  parameter int SHIFT_STEP = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_signal,
  input  logic                 busy_in,
  input  logic [3:0]           opcode_in,
  input  logic [31:0]          lhs_in,
  input  logic [31:0]          rhs_in,
  input  logic [ROB_WIDTH-1:0] rd_tag_in,
  output logic                 done_out,
  output logic [31:0]          value_out,
  output logic [ROB_WIDTH-1:0] tag_out
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_EQ   = 4'd10;
  localparam logic [3:0] OP_NE   = 4'd11;
  localparam logic [3:0] OP_LT   = 4'd12;
  localparam logic [3:0] OP_GE   = 4'd13;
  localparam logic [3:0] OP_LTU  = 4'd14;
  localparam logic [3:0] OP_GEU  = 4'd15;

  // SHIFT_STEP is at most 16, so it fits the 5-bit distance once compared
  // against the zero-extended counter.
  localparam logic [5:0] STEP_MAX = 6'(SHIFT_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_nxt;
  logic [3:0]             op_q, op_nxt;
  logic [31:0]            a_q, a_nxt;      // lhs, and the working value while shifting
  logic [31:0]            b_q, b_nxt;
  logic [4:0]             cnt_q, cnt_nxt;
  logic [ROB_WIDTH-1:0]   rtag_q, rtag_nxt;
  logic                   done_nxt;
  logic [31:0]            value_nxt;
  logic [ROB_WIDTH-1:0]   tag_nxt;

  logic [31:0]            alu_res;
  logic [31:0]            shift_res;
  logic [4:0]             step;
  logic                   is_shift_in;

  assign is_shift_in = (opcode_in == OP_SLL) || (opcode_in == OP_SRL) ||
                       (opcode_in == OP_SRA);

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_SLL:  alu_res = a_q << b_q[4:0];
      OP_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
      OP_SLTU: alu_res = {31'd0, a_q < b_q};
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SRL:  alu_res = a_q >> b_q[4:0];
      OP_SRA:  alu_res = 32'($signed(a_q) >>> b_q[4:0]);
      OP_OR:   alu_res = a_q | b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_EQ:   alu_res = {31'd0, a_q == b_q};
      OP_NE:   alu_res = {31'd0, a_q != b_q};
      OP_LT:   alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
      OP_GE:   alu_res = {31'd0, $signed(a_q) >= $signed(b_q)};
      OP_LTU:  alu_res = {31'd0, a_q < b_q};
      OP_GEU:  alu_res = {31'd0, a_q >= b_q};
      default: alu_res = '0;
    endcase
  end

  // Distance moved this iteration: min(cnt, SHIFT_STEP).
  assign step = ({1'b0, cnt_q} > STEP_MAX) ? STEP_MAX[4:0] : cnt_q;

  always_comb begin
    shift_res = a_q;
    case (op_q)
      OP_SLL:  shift_res = a_q << step;
      OP_SRL:  shift_res = a_q >> step;
      OP_SRA:  shift_res = 32'($signed(a_q) >>> step);
      default: shift_res = a_q;
    endcase
  end

  always_comb begin
    state_nxt = state_q;
    op_nxt    = op_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    cnt_nxt   = cnt_q;
    rtag_nxt  = rtag_q;
    done_nxt  = done_out;
    value_nxt = value_out;
    tag_nxt   = tag_out;

    if (clear_signal) begin
      // Flush: drop the op but leave the last broadcast value/tag in place.
      state_nxt = S_IDLE;
      done_nxt  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (busy_in) begin
            op_nxt    = opcode_in;
            a_nxt     = lhs_in;
            b_nxt     = rhs_in;
            cnt_nxt   = rhs_in[4:0];
            rtag_nxt  = rd_tag_in;
            state_nxt = is_shift_in ? S_SHIFT : S_EXEC;
          end
        end
        S_EXEC: begin
          value_nxt = alu_res;
          tag_nxt   = rtag_q;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end
        S_SHIFT: begin
          if (cnt_q != 5'd0) begin
            a_nxt   = shift_res;
            cnt_nxt = cnt_q - step;
          end else begin
            value_nxt = a_q;
            tag_nxt   = rtag_q;
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          done_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
        default: begin
          done_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      rtag_q    <= '0;
      done_out  <= 1'b0;
      value_out <= '0;
      tag_out   <= '0;
    end else if (rdy_in) begin
      state_q   <= state_nxt;
      op_q      <= op_nxt;
      a_q       <= a_nxt;
      b_q       <= b_nxt;
      cnt_q     <= cnt_nxt;
      rtag_q    <= rtag_nxt;
      done_out  <= done_nxt;
      value_out <= value_nxt;
      tag_out   <= tag_nxt;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: self-checking bench for alu_unit.
// A vector table drives single operations; expected value, tag and done cycle
// go to a scoreboard queue that a negedge monitor pops on each done pulse.
// Hand-written sequences cover stalls, mid-shift freeze and flushes.
module tb_alu_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_signal;
  logic        busy_in;
  logic [3:0]  opcode_in;
  logic [31:0] lhs_in;
  logic [31:0] rhs_in;
  logic [3:0]  rd_tag_in;
  logic        done_out;
  logic [31:0] value_out;
  logic [3:0]  tag_out;

  alu_unit #(.ROB_WIDTH(4), .SHIFT_STEP(8)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear_signal (clear_signal),
    .busy_in      (busy_in),
    .opcode_in    (opcode_in),
    .lhs_in       (lhs_in),
    .rhs_in       (rhs_in),
    .rd_tag_in    (rd_tag_in),
    .done_out     (done_out),
    .value_out    (value_out),
    .tag_out      (tag_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] val;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  logic prev_done = 1'b0;

  always @(posedge clk_in) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: one pop per rising done pulse.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (done_out && !prev_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {31'd0, done_out}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_value", value_out, e.val);
          check("sb_tag", {28'd0, tag_out}, {28'd0, e.tag});
          check("sb_latency", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_done = done_out;
    end
  end

  // Wait for done, release busy on the edge that samples it, confirm the
  // pulse is one cycle wide, then leave one idle cycle before the next op.
  task automatic wait_done_release();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk_in);
      if (done_out) seen = 1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    @(posedge clk_in); #1;
    busy_in = 1'b0;
    @(negedge clk_in);
    check("done_fall", {31'd0, done_out}, 32'd0);
    @(posedge clk_in); #1;
  endtask

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] rhs);
    int sh;
    sh = int'(rhs[4:0]);
    if (op == 4'd2 || op == 4'd6 || op == 4'd7) return 2 + (sh + 7) / 8;
    return 2;
  endfunction

  task automatic dispatch(input logic [3:0] op, input logic [31:0] l, input logic [31:0] r,
                          input logic [3:0] t, input logic [31:0] ev, input int lat);
    exp_t e;
    opcode_in = op; lhs_in = l; rhs_in = r; rd_tag_in = t; busy_in = 1'b1;
    e.val = ev; e.tag = t; e.cyc = cyc + lat;
    sb.push_back(e);
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{4'd0,  32'hFFFF_FFFF, 32'd2,          4'd5,  32'd1},
      '{4'd1,  32'd3,         32'd5,          4'd1,  32'hFFFF_FFFE},
      '{4'd4,  32'd1,         32'hFFFF_FFFF,  4'd2,  32'd1},
      '{4'd12, 32'd1,         32'hFFFF_FFFF,  4'd3,  32'd0},
      '{4'd7,  32'h8000_0000, 32'h0000_003F,  4'd4,  32'hFFFF_FFFF},
      '{4'd2,  32'h0000_1234, 32'd32,         4'd6,  32'h0000_1234},
      '{4'd6,  32'hF000_0000, 32'd4,          4'd7,  32'h0F00_0000},
      '{4'd2,  32'h0000_0001, 32'd9,          4'd8,  32'h0000_0200},
      '{4'd6,  32'h8000_0000, 32'd8,          4'd9,  32'h0080_0000},
      '{4'd3,  32'hFFFF_FFFF, 32'd0,          4'd10, 32'd1},
      '{4'd5,  32'hA5A5_A5A5, 32'hFFFF_0000,  4'd11, 32'h5A5A_A5A5},
      '{4'd8,  32'h0000_00F0, 32'h0000_0F00,  4'd12, 32'h0000_0FF0},
      '{4'd9,  32'h0000_F0F0, 32'h0000_FF00,  4'd13, 32'h0000_F000},
      '{4'd10, 32'd7,         32'd7,          4'd14, 32'd1},
      '{4'd11, 32'd7,         32'd7,          4'd15, 32'd0},
      '{4'd13, 32'hFFFF_FFFF, 32'd1,          4'd0,  32'd0},
      '{4'd14, 32'd1,         32'hFFFF_FFFF,  4'd1,  32'd1},
      '{4'd15, 32'hFFFF_FFFF, 32'd1,          4'd2,  32'd1},
      '{4'd7,  32'h7FFF_FFF0, 32'd4,          4'd3,  32'h07FF_FFFF},
      '{4'd7,  32'h8000_0000, 32'd16,         4'd4,  32'hFFFF_8000}
    };

    rst_in = 1'b1; rdy_in = 1'b1; clear_signal = 1'b0; busy_in = 1'b0;
    opcode_in = '0; lhs_in = '0; rhs_in = '0; rd_tag_in = '0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    check("rst_done", {31'd0, done_out}, 32'd0);
    check("rst_value", value_out, 32'd0);
    check("rst_tag", {28'd0, tag_out}, 32'd0);
    prev_done = done_out;
    mon_en = 1;
    @(posedge clk_in); #1;

    foreach (vecs[i]) begin
      dispatch(vecs[i].op, vecs[i].lhs, vecs[i].rhs, vecs[i].tag, vecs[i].exp,
               exp_lat(vecs[i].op, vecs[i].rhs));
      wait_done_release();
    end

    // rdy_in low for two edges mid-shift: SRA shamt 31 finishes two cycles late.
    dispatch(4'd7, 32'h8000_0000, 32'h0000_001F, 4'd11, 32'hFFFF_FFFF, 8);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1 rdy_in = 1'b0;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1 rdy_in = 1'b1;
    wait_done_release();

    // Stall in the done cycle: outputs held three cycles, one more, then low.
    dispatch(4'd0, 32'd10, 32'd20, 4'd6, 32'd30, 2);
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk_in);
        if (done_out) seen = 1;
      end
      check("stall_done_seen", {31'd0, seen}, 32'd1);
    end
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("stall_done_hold", {31'd0, done_out}, 32'd1);
      check("stall_value_hold", value_out, 32'd30);
      check("stall_tag_hold", {28'd0, tag_out}, 32'd6);
    end
    rdy_in = 1'b1;
    @(posedge clk_in); #1 busy_in = 1'b0;
    @(negedge clk_in);
    check("stall_done_fall", {31'd0, done_out}, 32'd0);
    @(posedge clk_in); #1;

    // Flush mid-shift (SRL shamt 24), then a flush on the accept edge.
    // Neither may ever produce a done pulse; value/tag keep the last result.
    opcode_in = 4'd6; lhs_in = 32'hFFFF_0000; rhs_in = 32'd24; rd_tag_in = 4'd9;
    busy_in = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1 clear_signal = 1'b1; busy_in = 1'b0;
    @(posedge clk_in); #1 clear_signal = 1'b0;
    @(posedge clk_in); #1 clear_signal = 1'b1; busy_in = 1'b1; rd_tag_in = 4'd12;
    @(posedge clk_in); #1 clear_signal = 1'b0; busy_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      check("clr_no_done", {31'd0, done_out}, 32'd0);
    end
    check("clr_value_kept", value_out, 32'd30);
    check("clr_tag_kept", {28'd0, tag_out}, 32'd6);
    @(posedge clk_in); #1;
    dispatch(4'd0, 32'd100, 32'd23, 4'd3, 32'd123, 2);
    wait_done_release();

    repeat (4) @(posedge clk_in);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

Multi-cycle integer execution unit on the result side of the reservation station's ALU dispatch port. Two instances exist, one per dispatch lane. Each accepts one operation while the station holds its per-lane busy line high, computes the RV32I integer or compare result, and returns a one-cycle done pulse with value and ROB tag on the broadcast bus. The station, ROB and LSB snoop that bus. Shifts run iteratively; all other operations complete in a fixed latency.

## Interface
- ROB_WIDTH, 4, ROB tag width.
- SHIFT_STEP, 8, maximum shift distance per iteration cycle (power of two, 1..16).

- clk_in  input  1  system clock.
- rst_in  input  1  reset; one clock; synchronous, active-high.
- rdy_in  input  1  global enable; when low, all state and outputs hold.
- clear_signal  input  1  misprediction flush; aborts any in-flight op.
- busy_in  input  1  task-valid level from the station (its busy_alu_N).
- opcode_in  input  4  operation select.
- lhs_in  input  32  operand 1.
- rhs_in  input  32  operand 2.
- rd_tag_in  input  ROB_WIDTH  destination ROB tag.
- done_out  output  1  result valid (one-cycle pulse at rdy_in-high edges).
- value_out  output  32  result.
- tag_out  output  ROB_WIDTH  ROB tag of the result.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA.
  - 8 OR, 9 AND, 10 EQ, 11 NE, 12 LT, 13 GE, 14 LTU, 15 GEU.
- Arithmetic wraps modulo 2^32.
- Comparison opcodes (3, 4, 10-15) return 32'd1 or 32'd0. LT, GE and SLT are signed; the U variants are unsigned.
- Shift amount is rhs[4:0]; rhs[31:5] is ignored. SRA replicates lhs[31].
- State machine:
  - IDLE: when busy_in is 1, latch opcode, lhs, rhs[4:0] (as counter cnt) and rd_tag. Go to SHIFT for opcodes 2, 6 and 7; otherwise go to EXEC.
  - EXEC: compute the result. Register value_out, tag_out and done_out=1. Go to DONE.
  - SHIFT, cnt != 0: shift the working value by min(cnt, SHIFT_STEP); decrement cnt by that amount; stay in SHIFT.
  - SHIFT, cnt == 0: register the working value into value_out, set tag_out and done_out=1. Go to DONE.
  - DONE: done_out<=0; go to IDLE. busy_in is ignored in this state, because the station lowers it only on the edge that sampled done.
- busy_in dropping in EXEC or SHIFT without clear_signal is a protocol violation. The unit ignores it and completes the op.
- Priority at each edge: rst_in, then rdy_in low (hold), then clear_signal, then normal operation.
- clear_signal with rdy_in high: state<=IDLE, done_out<=0. value_out and tag_out keep their old values. This applies in every state, including DONE and the accept edge. A busy_in present in that cycle is not accepted.

## Timing
- Reset values: done_out=0, value_out=0, tag_out=0, state IDLE, cnt=0.
- Cycle A: busy_in first seen high in IDLE. The accept edge is the end of cycle A.
- Non-shift op: done_out=1 during cycle A+2.
- Shift op: done_out=1 during cycle A+2+ceil(shamt/SHIFT_STEP).
  - With SHIFT_STEP=8: shamt 0 gives A+2; shamt 31 gives A+6.
- done_out is high for exactly one rdy_in-high edge. If rdy_in is low while done_out=1, done_out, value_out and tag_out stay asserted until the next rdy_in-high edge.
- value_out and tag_out change only on the edge that raises done_out, or on reset.
- Back-to-back: the station redispatches the cycle after done falls, so the next cycle A is at least 2 cycles after the previous done cycle.
- rdy_in low freezes cnt and the working value mid-shift. Each rdy_in-high edge counts as one latency cycle.

## Test plan
- ADD: lhs=0xFFFFFFFF, rhs=2, tag=5 at cycle A → done at A+2 with value=1, tag=5; done low at A+3.
- SUB and SLTU: SUB 3-5 → 0xFFFFFFFE. SLTU lhs=1, rhs=0xFFFFFFFF → 1. LT with the same operands → 0.
- SRA: lhs=0x80000000, rhs=0x3F (shamt 31) → done at A+6 with value=0xFFFFFFFF.
- SLL shamt 0: lhs=0x1234, rhs=32 → done at A+2 with value=0x1234.
- Stall: rdy_in held low 3 cycles starting in the done cycle → done_out, value and tag held 3 cycles, then one more rdy-high cycle, then done low.
- Clear: clear_signal at A+3 during SRL shamt 24 → IDLE next cycle, no done pulse ever. A fresh ADD dispatched next completes at its own A+2 with the correct tag.
